// File: rtl/sa_fifo_ctl_19x80_pkg.sv
// Shared constants and types for the 19x80 systolic-array FIFO controller.
// Optional bypass is selected with the SA_FIFO_CTL_BYPASS_EN macro in the top.
package sa_fifo_ctl_pkg;

    localparam int DEPTH = 19;
    localparam int WIDTH = 80;
    localparam int AW    = 5;
    localparam int CW    = 5;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Pointers wrap from the last RAM slot straight back to 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/sa_fifo_ctl_19x80_rd_pipe.sv
// Two-stage read pipeline tracking: stage 1 = RAM read address latched,
// stage 2 = RAM output register holds data presented to the consumer.
module sa_fifo_rd_pipe (
    input  logic clk,
    input  logic rst,
    input  logic issue_ok,
    input  logic byp_req,
    input  logic rd_prdy,
    output logic s2_vld,
    output logic re,
    output logic ore,
    output logic pop,
    output logic s1_adv,
    output logic byp
);

    logic s1_vld;

    always_comb begin
        pop    = s2_vld & rd_prdy;
        s1_adv = s1_vld & (~s2_vld | rd_prdy);
        // Fall-through only when nothing older is in flight ahead of the write.
        byp    = byp_req & ~s1_vld & (~s2_vld | rd_prdy);
        // Holding re low while stage 1 stalls keeps the RAM's latched address.
        re     = ~rst & issue_ok & (~s1_vld | s1_adv);
        ore    = ~rst & (s1_adv | byp);
    end

    // Stage 1 / stage 2 valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (re) begin
                s1_vld <= 1'b1;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            s2_vld <= (s2_vld & ~pop) | ore;
        end
    end

endmodule

// File: rtl/sa_fifo_ctl_19x80.sv
// Valid/ready FIFO controller driving a 19x80 RAM plus its output register as a
// 20-deep FIFO. Define SA_FIFO_CTL_BYPASS_EN for 1-cycle fall-through when empty.
module sa_fifo_ctl_19x80
    import sa_fifo_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_dbyp,
    output cnt_t             fifo_cnt,
    output logic             idle
);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t ram_cnt;
    cnt_t ram_cnt_next;
    cnt_t unissued;
    cnt_t unissued_next;
    logic wr_prdy_q;
    logic accept;
    logic ram_wr;
    logic byp_req;
    logic byp;
    logic s2_vld;
    logic pop;
    logic s1_adv;
    logic ore;
    logic re;

    assign wr_prdy = wr_prdy_q & ~rst;
    assign accept  = wr_pvld & wr_prdy;

`ifdef SA_FIFO_CTL_BYPASS_EN
    assign byp_req     = accept & (ram_cnt == '0);
    assign ram_byp_sel = byp;
    assign ram_dbyp    = wr_pd;
`else
    assign byp_req     = 1'b0;
    assign ram_byp_sel = 1'b0;
    assign ram_dbyp    = '0;
`endif

    sa_fifo_rd_pipe u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .issue_ok (unissued != '0),
        .byp_req  (byp_req),
        .rd_prdy  (rd_prdy),
        .s2_vld   (s2_vld),
        .re       (re),
        .ore      (ore),
        .pop      (pop),
        .s1_adv   (s1_adv),
        .byp      (byp)
    );

    assign ram_wr  = accept & ~byp;
    assign ram_we  = ram_wr;
    assign ram_wa  = wr_ptr;
    assign ram_di  = wr_pd;
    assign ram_re  = re;
    assign ram_ra  = rd_ptr;
    assign ram_ore = ore;

    assign rd_pvld  = s2_vld;
    assign rd_pd    = ram_dout;
    assign fifo_cnt = ram_cnt + cnt_t'(s2_vld);
    assign idle     = (fifo_cnt == '0) & ~accept;

    // A RAM slot is released only once stage 2 has captured its data.
    always_comb begin
        ram_cnt_next = ram_cnt;
        case ({ram_wr, s1_adv})
            2'b10:   ram_cnt_next = ram_cnt + cnt_t'(1);
            2'b01:   ram_cnt_next = ram_cnt - cnt_t'(1);
            default: ram_cnt_next = ram_cnt;
        endcase
    end

    always_comb begin
        unissued_next = unissued;
        case ({ram_wr, re})
            2'b10:   unissued_next = unissued + cnt_t'(1);
            2'b01:   unissued_next = unissued - cnt_t'(1);
            default: unissued_next = unissued;
        endcase
    end

    // Pointer, occupancy and ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            unissued  <= '0;
            wr_prdy_q <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (re) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            ram_cnt   <= ram_cnt_next;
            unissued  <= unissued_next;
            wr_prdy_q <= (ram_cnt_next < cnt_t'(DEPTH));
        end
    end

endmodule

// File: tb/tb_sa_fifo_ctl_19x80.sv
// Self-checking bench for sa_fifo_ctl_19x80 with a behavioural 19x80 RAM model.
// Expectations follow SA_FIFO_CTL_BYPASS_EN when that macro is defined.
module tb_sa_fifo_ctl_19x80;
    import sa_fifo_ctl_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_pvld;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd;
    logic             rd_pvld;
    logic             rd_prdy;
    logic [WIDTH-1:0] rd_pd;
    logic [AW-1:0]    ram_ra;
    logic             ram_re;
    logic             ram_ore;
    logic [WIDTH-1:0] ram_dout;
    logic [AW-1:0]    ram_wa;
    logic             ram_we;
    logic [WIDTH-1:0] ram_di;
    logic             ram_byp_sel;
    logic [WIDTH-1:0] ram_dbyp;
    cnt_t             fifo_cnt;
    logic             idle;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa_fifo_ctl_19x80 dut (
        .clk(clk), .rst(rst), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp),
        .fifo_cnt(fifo_cnt), .idle(idle)
    );

    // Behavioural RAM: write port, latched read address, gated output register.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_d;
    logic [WIDTH-1:0] dout_q;
    logic             tb_s1;

    always @(posedge clk) begin
        if (ram_we && ram_wa < AW'(DEPTH)) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) dout_q <= ram_byp_sel ? ram_dbyp : ((ra_d < AW'(DEPTH)) ? mem[ra_d] : '0);
    end
    assign ram_dout = dout_q;

    // Independent view of stage-1 occupancy, built from RAM strobes only.
    always @(posedge clk) begin
        if (rst) tb_s1 <= 1'b0;
        else if (ram_re) tb_s1 <= 1'b1;
        else if (ram_ore && !ram_byp_sel) tb_s1 <= 1'b0;
    end

    typedef struct {
        logic             wv;
        logic [WIDTH-1:0] wd;
        logic             rp;
        logic             e_wrdy;
        logic             e_vld;
        logic [WIDTH-1:0] e_pd;
        cnt_t             e_cnt;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    function automatic logic [WIDTH-1:0] mkval(input int i);
        logic [31:0] v;
        v = i;
        return {16'hC0DE, v, ~v};
    endfunction

    function automatic logic [WIDTH-1:0] pat(input int k);
        return {{19{4'hA}}, 4'(k)};
    endfunction

    function automatic vec_t mkv(input logic wv, input int k, input logic e_vld, input int ek, input int ecnt);
        vec_t v;
        v.wv = wv; v.wd = pat(k); v.rp = 1'b1; v.e_wrdy = 1'b1;
        v.e_vld = e_vld; v.e_pd = pat(ek); v.e_cnt = cnt_t'(ecnt);
        return v;
    endfunction

    task automatic stream(input int n, input int stall_pct, input int base, input bit chk_wrap);
        int sent = 0, rcvd = 0, cyc = 0, wraps_w = 0, wraps_r = 0, viol = 0, bad = 0;
        while (rcvd < n && cyc < n * 8 + 50) begin
            wr_pvld = (sent < n);
            wr_pd   = mkval(base + sent);
            rd_prdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (wr_pvld && wr_prdy) sent++;
            if (rd_pvld && rd_prdy) begin
                if (rd_pd !== mkval(base + rcvd)) bad++;
                rcvd++;
            end
            if (ram_we && ram_wa == 5'd18) wraps_w++;
            if (ram_re && ram_ra == 5'd18) wraps_r++;
            if ((ram_we && ram_wa > 5'd18) || (ram_re && ram_ra > 5'd18)) viol++;
            if (tb_s1 && rd_pvld && !rd_prdy && ram_re) viol++;
            if (rd_pvld && !rd_prdy && ram_ore) viol++;
            if (int'(fifo_cnt) - int'(rd_pvld) > DEPTH) viol++;
            next_cycle();
            cyc++;
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        chk("stream_count", WIDTH'(rcvd), WIDTH'(n));
        chk("stream_data_errs", WIDTH'(bad), '0);
        chk("stream_violations", WIDTH'(viol), '0);
        if (stall_pct == 0) chk("stream_throughput", WIDTH'(cyc <= n + 4), WIDTH'(1));
        if (chk_wrap) begin
            chk("wr_wraps", WIDTH'(wraps_w), WIDTH'(3));
            chk("rd_wraps", WIDTH'(wraps_r), WIDTH'(3));
        end
    endtask

    initial begin
        int acc;
        int got;
        logic [WIDTH-1:0] got_pd;

`ifdef SA_FIFO_CTL_BYPASS_EN
        tv[0] = mkv(1, 1, 0, 0, 0);
        tv[1] = mkv(1, 2, 1, 1, 1);
        tv[2] = mkv(1, 3, 1, 2, 1);
        tv[3] = mkv(1, 4, 1, 3, 1);
        tv[4] = mkv(1, 5, 1, 4, 1);
        tv[5] = mkv(0, 0, 1, 5, 1);
        tv[6] = mkv(0, 0, 0, 0, 0);
        tv[7] = mkv(0, 0, 0, 0, 0);
        tv[8] = mkv(0, 0, 0, 0, 0);
`else
        tv[0] = mkv(1, 1, 0, 0, 0);
        tv[1] = mkv(1, 2, 0, 0, 1);
        tv[2] = mkv(1, 3, 0, 0, 2);
        tv[3] = mkv(1, 4, 1, 1, 3);
        tv[4] = mkv(1, 5, 1, 2, 3);
        tv[5] = mkv(0, 0, 1, 3, 3);
        tv[6] = mkv(0, 0, 1, 4, 2);
        tv[7] = mkv(0, 0, 1, 5, 1);
        tv[8] = mkv(0, 0, 0, 0, 0);
`endif

        // Reset state, sampled while rst is still high.
        rst = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_wr_prdy", WIDTH'(wr_prdy), '0);
        chk("rst_rd_pvld", WIDTH'(rd_pvld), '0);
        chk("rst_fifo_cnt", WIDTH'(fifo_cnt), '0);
        chk("rst_enables", WIDTH'({ram_we, ram_re, ram_ore}), '0);
        chk("rst_idle", WIDTH'(idle), WIDTH'(1));

        // Test 1: table-driven short transfer with ready consumer.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_pvld = tv[i].wv; wr_pd = tv[i].wd; rd_prdy = tv[i].rp;
            @(negedge clk);
            chk($sformatf("t1_wr_prdy[%0d]", i), WIDTH'(wr_prdy), WIDTH'(tv[i].e_wrdy));
            chk($sformatf("t1_rd_pvld[%0d]", i), WIDTH'(rd_pvld), WIDTH'(tv[i].e_vld));
            chk($sformatf("t1_fifo_cnt[%0d]", i), WIDTH'(fifo_cnt), WIDTH'(tv[i].e_cnt));
            if (tv[i].e_vld) chk($sformatf("t1_rd_pd[%0d]", i), rd_pd, tv[i].e_pd);
            next_cycle();
        end
        wr_pvld = 1'b0;

        // Test 2: fill with a stalled consumer, then drain.
        do_reset();
        acc = 0;
        for (int i = 0; i < 25; i++) begin
            wr_pvld = 1'b1; wr_pd = mkval(acc); rd_prdy = 1'b0;
            @(negedge clk);
            if (wr_prdy) acc++;
            next_cycle();
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("t2_accepted", WIDTH'(acc), WIDTH'(20));
        chk("t2_wr_prdy_full", WIDTH'(wr_prdy), '0);
        chk("t2_fifo_cnt_full", WIDTH'(fifo_cnt), WIDTH'(20));
        next_cycle();
        got = 0;
        for (int i = 0; i < 60; i++) begin
            rd_prdy = 1'b1;
            @(negedge clk);
            if (rd_pvld) begin
                chk($sformatf("t2_drain[%0d]", got), rd_pd, mkval(got));
                got++;
            end
            next_cycle();
        end
        rd_prdy = 1'b0;
        chk("t2_drain_count", WIDTH'(got), WIDTH'(20));
        @(negedge clk);
        chk("t2_empty_cnt", WIDTH'(fifo_cnt), '0);
        next_cycle();

        // Test 3: back-to-back streaming with pointer wrap.
        do_reset();
`ifdef SA_FIFO_CTL_BYPASS_EN
        stream(60, 0, 100, 1'b0);
`else
        stream(60, 0, 100, 1'b1);
`endif

        // Test 4: random consumer stalls.
        stream(40, 50, 1000, 1'b0);
        next_cycle();

        // Test 5: reset in the middle of a partly full FIFO.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            wr_pvld = 1'b1; wr_pd = mkval(500 + i); rd_prdy = 1'b0;
            next_cycle();
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("t5_fill_cnt", WIDTH'(fifo_cnt), WIDTH'(12));
        next_cycle();
        rst = 1'b1; wr_pvld = 1'b1; wr_pd = mkval(999);
        @(negedge clk);
        chk("t5_rst_wr_prdy", WIDTH'(wr_prdy), '0);
        chk("t5_rst_enables", WIDTH'({ram_we, ram_re, ram_ore}), '0);
        next_cycle();
        rst = 1'b0; wr_pvld = 1'b0;
        @(negedge clk);
        chk("t5_post_rd_pvld", WIDTH'(rd_pvld), '0);
        chk("t5_post_fifo_cnt", WIDTH'(fifo_cnt), '0);
        chk("t5_post_wr_prdy", WIDTH'(wr_prdy), '0);
        next_cycle();
        wr_pvld = 1'b1; wr_pd = 80'h55;
        @(negedge clk);
        chk("t5_wr_prdy_back", WIDTH'(wr_prdy), WIDTH'(1));
        next_cycle();
        wr_pvld = 1'b0;
        got = 0; got_pd = '0;
        for (int i = 0; i < 10; i++) begin
            rd_prdy = 1'b1;
            @(negedge clk);
            if (rd_pvld) begin got++; got_pd = rd_pd; end
            next_cycle();
        end
        rd_prdy = 1'b0;
        chk("t5_out_count", WIDTH'(got), WIDTH'(1));
        chk("t5_out_value", got_pd, 80'h55);

        // Test 6: write into an empty FIFO.
        do_reset();
        wr_pvld = 1'b1; wr_pd = 80'hDEAD; rd_prdy = 1'b0;
        @(negedge clk);
`ifdef SA_FIFO_CTL_BYPASS_EN
        chk("t6_byp_we", WIDTH'(ram_we), '0);
        chk("t6_byp_sel", WIDTH'(ram_byp_sel), WIDTH'(1));
        chk("t6_byp_ore", WIDTH'(ram_ore), WIDTH'(1));
        next_cycle();
        wr_pd = 80'hBEEF;
        @(negedge clk);
        chk("t6_byp_vld", WIDTH'(rd_pvld), WIDTH'(1));
        chk("t6_byp_pd", rd_pd, 80'hDEAD);
        chk("t6_second_we", WIDTH'(ram_we), WIDTH'(1));
        chk("t6_second_wa", WIDTH'(ram_wa), '0);
        chk("t6_second_sel", WIDTH'(ram_byp_sel), '0);
        next_cycle();
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        @(negedge clk);
        chk("t6_pop_first", rd_pd, 80'hDEAD);
        next_cycle();
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            @(negedge clk);
            if (rd_pvld) begin
                got = 1;
                chk("t6_second_pd", rd_pd, 80'hBEEF);
            end
            next_cycle();
        end
        chk("t6_second_seen", WIDTH'(got), WIDTH'(1));
`else
        chk("t6_ram_we", WIDTH'(ram_we), WIDTH'(1));
        chk("t6_ram_wa", WIDTH'(ram_wa), '0);
        chk("t6_byp_sel_tied", WIDTH'(ram_byp_sel), '0);
        chk("t6_dbyp_tied", ram_dbyp, '0);
        next_cycle();
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("t6_not_fallthrough", WIDTH'(rd_pvld), '0);
        next_cycle();
`endif
        rd_prdy = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
